// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state type, default sizing and small op-classification helpers.
package mult_div_unit_pkg;

  localparam int MDU_WIDTH       = 32;
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  // 3-bit op codes also produced by the decoder; codes 6 and 7 are unused.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic isDivide(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic isMulDiv(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || isDivide(op);
  endfunction

endpackage

// File: rtl/mult_div_unit_calc.sv
// Purely combinational arithmetic for the MDU: produces the 64-bit {hi,lo}
// result of a multiply or divide, plus a flag for division by zero.
module mdu_calc
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               divByZero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic               signedOp;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   uQuot;
  logic [WIDTH-1:0]   uRem;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] prodS;
  logic [2*WIDTH-1:0] prodU;

  // Division works on magnitudes and re-applies signs, which gives truncation
  // toward zero, a dividend-signed remainder and the MIN/-1 wrap for free.
  always_comb begin
    signedOp  = (op == MDU_MULT) || (op == MDU_DIV);
    magA      = (signedOp && a[WIDTH-1]) ? -a : a;
    magB      = (signedOp && b[WIDTH-1]) ? -b : b;
    divisor   = (magB == '0) ? ONE : magB;
    uQuot     = magA / divisor;
    uRem      = magA % divisor;
    quot      = (signedOp && (a[WIDTH-1] ^ b[WIDTH-1])) ? -uQuot : uQuot;
    rem       = (signedOp && a[WIDTH-1]) ? -uRem : uRem;
    prodS     = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prodU     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    divByZero = (b == '0) && isDivide(op);
    result    = '0;
    case (op)
      MDU_MULT:          result = prodS;
      MDU_MULTU:         result = prodU;
      MDU_DIV, MDU_DIVU: result = {rem, quot};
      default:           result = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage HI/LO multiply/divide unit. Latches the result at the start edge,
// counts down the configured latency, then commits to HI/LO. Reports
// busy/stall to the hazard unit; MTHI/MTLO write directly when idle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH       = MDU_WIDTH,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0]   counter_q,   counter_d;
  logic [WIDTH-1:0]   pendingHi_q, pendingHi_d;
  logic [WIDTH-1:0]   pendingLo_q, pendingLo_d;
  logic [WIDTH-1:0]   hi_q,        hi_d;
  logic [WIDTH-1:0]   lo_q,        lo_d;
  logic [2*WIDTH-1:0] calcResult;
  logic               calcDivByZero;
  mdu_state_e         curState;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op        (op),
    .a         (a),
    .b         (b),
    .result    (calcResult),
    .divByZero (calcDivByZero)
  );

  assign curState = (counter_q != '0) ? MDU_RUN : MDU_IDLE;

  // State register: counter, pending result and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      counter_q   <= '0;
      pendingHi_q <= '0;
      pendingLo_q <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      counter_q   <= counter_d;
      pendingHi_q <= pendingHi_d;
      pendingLo_q <= pendingLo_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  // Next state: accept ops only when idle; count down and commit when running.
  always_comb begin
    counter_d   = counter_q;
    pendingHi_d = pendingHi_q;
    pendingLo_d = pendingLo_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (curState)
      MDU_IDLE: begin
        if (start) begin
          if (isMulDiv(op)) begin
            counter_d = isDivide(op) ? DIV_LOAD : MULT_LOAD;
            if (calcDivByZero) begin
              pendingHi_d = hi_q;
              pendingLo_d = lo_q;
            end else begin
              pendingHi_d = calcResult[2*WIDTH-1:WIDTH];
              pendingLo_d = calcResult[WIDTH-1:0];
            end
          end else if (op == MDU_MTHI) begin
            hi_d = a;
          end else if (op == MDU_MTLO) begin
            lo_d = a;
          end
        end
      end
      MDU_RUN: begin
        if (counter_q == CNT_ONE) begin
          hi_d      = pendingHi_q;
          lo_d      = pendingLo_q;
          counter_d = '0;
        end else begin
          counter_d = counter_q - CNT_ONE;
        end
      end
      default: counter_d = '0;
    endcase
  end

  // Outputs: busy from the counter, stall also covers a mul/div being presented.
  always_comb begin
    busy      = (curState == MDU_RUN);
    stall_req = busy | (start & isMulDiv(op));
    hi        = hi_q;
    lo        = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: table of arithmetic vectors plus
// hand-written sequences for reset, divide by zero, collisions and abort.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          cycles;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  vec_t vecs[10];

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] o,
                               input logic [31:0] x, input logic [31:0] y);
    start = s;
    op    = o;
    a     = x;
    b     = y;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic writeSingle(input logic [2:0] o, input logic [31:0] x);
    applyStimulus(1'b1, o, x, 32'h0);
    tick();
    applyStimulus(1'b0, MDU_MULT, 32'h0, 32'h0);
  endtask

  // Issues a mul/div, scrambles operands afterwards, checks busy each cycle and the commit.
  task automatic runOp(input string name, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int cycles,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    applyStimulus(1'b1, o, x, y);
    checkOutput({name, " stall_req at start"}, 32'(stall_req), 32'h1);
    tick();
    applyStimulus(1'b0, o, $urandom, $urandom);
    for (int i = 1; i <= cycles; i++) begin
      checkOutput($sformatf("%s busy cycle %0d", name, i), 32'(busy), 32'h1);
      tick();
    end
    checkOutput({name, " busy after"}, 32'(busy), 32'h0);
    checkOutput({name, " hi"}, hi, expHi);
    checkOutput({name, " lo"}, lo, expLo);
  endtask

  initial begin
    vecs[0] = '{"MULT neg",    MDU_MULT,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{"MULTU",       MDU_MULTU, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{"DIV neg",     MDU_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{"DIVU",        MDU_DIVU,  32'h7,        32'h2,        32'h00000001, 32'h00000003, 10};
    vecs[4] = '{"DIV ovf",     MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{"DIV negdiv",  MDU_DIV,   32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{"MULTU max",   MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[7] = '{"MULT 2^32",   MDU_MULT,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[8] = '{"DIVU by 10",  MDU_DIVU,  32'hFFFFFFFF, 32'hA,        32'h00000005, 32'h19999999, 10};
    vecs[9] = '{"MULT minsq",  MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

    reset_n = 1'b0;
    applyStimulus(1'b0, MDU_MULT, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset hi", hi, 32'h0);
    checkOutput("reset lo", lo, 32'h0);
    reset_n = 1'b1;
    tick();

    // Reset after random HI/LO writes.
    writeSingle(MDU_MTHI, $urandom | 32'h1);
    writeSingle(MDU_MTLO, $urandom | 32'h1);
    reset_n = 1'b0;
    tick();
    tick();
    checkOutput("reset2 hi", hi, 32'h0);
    checkOutput("reset2 lo", lo, 32'h0);
    checkOutput("reset2 busy", 32'(busy), 32'h0);
    checkOutput("reset2 stall_req", 32'(stall_req), 32'h0);
    reset_n = 1'b1;
    tick();

    // MTHI/MTLO are single cycle and never stall.
    applyStimulus(1'b1, MDU_MTHI, 32'hCAFEF00D, 32'h0);
    checkOutput("MTHI stall_req", 32'(stall_req), 32'h0);
    tick();
    applyStimulus(1'b0, MDU_MULT, 32'h0, 32'h0);
    checkOutput("MTHI busy", 32'(busy), 32'h0);
    checkOutput("MTHI hi", hi, 32'hCAFEF00D);
    writeSingle(MDU_MTLO, 32'h0BADBEEF);
    checkOutput("MTLO lo", lo, 32'h0BADBEEF);
    checkOutput("MTLO hi kept", hi, 32'hCAFEF00D);

    // Undefined op code.
    applyStimulus(1'b1, 3'd6, 32'h11111111, 32'h22222222);
    checkOutput("undef stall_req", 32'(stall_req), 32'h0);
    tick();
    applyStimulus(1'b0, MDU_MULT, 32'h0, 32'h0);
    checkOutput("undef busy", 32'(busy), 32'h0);
    checkOutput("undef hi", hi, 32'hCAFEF00D);
    checkOutput("undef lo", lo, 32'h0BADBEEF);

    // Arithmetic vector table.
    for (int v = 0; v < 10; v++) begin
      runOp(vecs[v].name, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].cycles,
            vecs[v].expHi, vecs[v].expLo);
      tick();
    end

    // Divide by zero leaves HI/LO untouched.
    writeSingle(MDU_MTHI, 32'h1234);
    writeSingle(MDU_MTLO, 32'h5678);
    runOp("DIV by zero", MDU_DIV, 32'h5, 32'h0, 10, 32'h1234, 32'h5678);

    // MTLO held in EX while a MULT is busy, then reissued.
    runOp("pre MTHI", MDU_MULTU, 32'h0, 32'h0, 5, 32'h0, 32'h0);
    applyStimulus(1'b1, MDU_MULT, 32'h3, 32'h4);
    tick();
    applyStimulus(1'b0, MDU_MULT, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, MDU_MTLO, 32'hAAAA, 32'h0);
    checkOutput("collide MTLO stall_req", 32'(stall_req), 32'h1);
    for (int g = 0; g < 20 && busy; g++) tick();
    checkOutput("collide wait busy", 32'(busy), 32'h0);
    checkOutput("collide MULT hi", hi, 32'h0);
    checkOutput("collide MULT lo", lo, 32'hC);
    checkOutput("collide reissue stall_req", 32'(stall_req), 32'h0);
    tick();
    applyStimulus(1'b0, MDU_MULT, 32'h0, 32'h0);
    checkOutput("reissued MTLO lo", lo, 32'hAAAA);
    checkOutput("reissued MTLO hi", hi, 32'h0);

    // Second MULT while busy is ignored: timing and result stay with the first.
    applyStimulus(1'b1, MDU_MULT, 32'h3, 32'h4);
    tick();
    applyStimulus(1'b0, MDU_MULT, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, MDU_MULT, 32'h5, 32'h5);
    checkOutput("second MULT stall_req", 32'(stall_req), 32'h1);
    tick();
    applyStimulus(1'b0, MDU_MULT, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("second MULT busy T+5", 32'(busy), 32'h1);
    tick();
    checkOutput("second MULT busy T+6", 32'(busy), 32'h0);
    checkOutput("second MULT lo", lo, 32'hC);
    tick();
    checkOutput("second MULT busy T+7", 32'(busy), 32'h0);
    checkOutput("second MULT lo T+7", lo, 32'hC);

    // Reset in cycle T+3 of a DIV aborts it without a late commit.
    writeSingle(MDU_MTHI, 32'h55);
    writeSingle(MDU_MTLO, 32'h66);
    applyStimulus(1'b1, MDU_DIV, 32'd100, 32'd7);
    tick();
    applyStimulus(1'b0, MDU_MULT, 32'h0, 32'h0);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("abort busy", 32'(busy), 32'h0);
    checkOutput("abort hi", hi, 32'h0);
    checkOutput("abort lo", lo, 32'h0);
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput($sformatf("abort late busy %0d", i), 32'(busy), 32'h0);
    end
    checkOutput("abort late hi", hi, 32'h0);
    checkOutput("abort late lo", lo, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
